// File: rtl/lsu_defs_pkg.sv
// Shared LSU encodings: access sizes, master FSM states
// and the alignment rule used at request acceptance.
package lsu_defs_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AWW  = 3'd3,
    B    = 3'd4,
    RESP = 3'd5
  } state_e;

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    logic bad;
    bad = 1'b0;
    unique case (1'b1)
      size == SZ_HALF: bad = lo[0];
      size == SZ_WORD: bad = |lo;
      size == SZ_RSVD: bad = 1'b1;
      default:         bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load-data extension: byte/half sign or zero
// extension, word passthrough.
module lsu_load_ext
  import lsu_defs_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    unique case (1'b1)
      size == SZ_BYTE:
        data = {{24{~uns & raw[7]}}, raw[7:0]};
      size == SZ_HALF:
        data = {{16{~uns & raw[15]}}, raw[15:0]};
      default:
        data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_axi_master.sv
// Single-outstanding LSU bus master: one load or store per
// request, with alignment check and per-handshake timeout.
module lsu_axi_master
  import lsu_defs_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] araddr,
  output logic [1:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic [31:0] awaddr,
  output logic [1:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CW = $clog2(TIMEOUT + 1) + 1;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] ext_data;
  logic        tmo;
  logic        busy;

  lsu_load_ext u_ext (
    .raw  (rdata),
    .size (size_q),
    .uns  (uns_q),
    .data (ext_data)
  );

  assign tmo  = (cnt_q == CW'(TIMEOUT));
  assign busy = (state_q == AR) || (state_q == R) ||
                (state_q == AWW) || (state_q == B);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    uns_d       = uns_q;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          wdata_d = req_wdata;
          we_d    = req_we;
          uns_d   = req_unsigned;
          if (misaligned(req_size, req_addr[1:0])) begin
            state_d   = RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d = req_we ? AWW : AR;
          end
        end
      end
      AR: begin
        if (tmo) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else if (arready) begin
          state_d = R;
        end
      end
      R: begin
        if (tmo) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else if (rready_q && rvalid) begin
          state_d     = RESP;
          rsp_rdata_d = we_q ? '0 : ext_data;
        end
      end
      AWW: begin
        if (tmo) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else if ((!awvalid_q || awready) &&
                     (!wvalid_q || wready)) begin
          state_d = B;
        end
      end
      B: begin
        if (tmo) begin
          state_d   = RESP;
          rsp_err_d = 1'b1;
        end else if (bready_q && bvalid) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // valids rise on entry; readies one cycle into the state
    arvalid_d   = (state_d == AR);
    rready_d    = (state_q == R) && (state_d == R);
    awvalid_d   = (state_d == AWW) &&
                  ((state_q == IDLE) || (awvalid_q && !awready));
    wvalid_d    = (state_d == AWW) &&
                  ((state_q == IDLE) || (wvalid_q && !wready));
    bready_d    = (state_q == B) && (state_d == B);
    rsp_valid_d = (state_d == RESP);
    cnt_d       = (busy && state_d == state_q) ? cnt_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign araddr    = addr_q;
  assign arsize    = size_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign awaddr    = addr_q;
  assign awsize    = size_q;
  assign awvalid   = awvalid_q;
  assign wdata     = wdata_q;
  assign wvalid    = wvalid_q;
  assign bready    = bready_q;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Directed bench for lsu_axi_master: loads, stores, alignment,
// timeout and mid-transaction reset.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] araddr;
  logic [1:0]  arsize;
  logic        arvalid;
  logic        arready = 1'b1;
  logic [31:0] rdata = '0;
  logic        rvalid = 1'b1;
  logic        rready;
  logic [31:0] awaddr;
  logic [1:0]  awsize;
  logic        awvalid;
  logic        awready = 1'b1;
  logic [31:0] wdata;
  logic        wvalid;
  logic        wready = 1'b1;
  logic        bvalid = 1'b1;
  logic        bready;

  always #5 clk = ~clk;

  lsu_axi_master #(.TIMEOUT(255)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .araddr       (araddr),
    .arsize       (arsize),
    .arvalid      (arvalid),
    .arready      (arready),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .rready       (rready),
    .awaddr       (awaddr),
    .awsize       (awsize),
    .awvalid      (awvalid),
    .awready      (awready),
    .wdata        (wdata),
    .wvalid       (wvalid),
    .wready       (wready),
    .bvalid       (bvalid),
    .bready       (bready)
  );

  int total = 0;
  int bad = 0;
  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_rsp = 0;
  logic [31:0] last_araddr = '0;
  logic [31:0] last_awaddr = '0;
  logic [31:0] last_wdata = '0;

  always @(negedge clk) begin
    if (arvalid) begin
      n_ar <= n_ar + 1;
      last_araddr <= araddr;
    end
    if (awvalid) begin
      n_aw <= n_aw + 1;
      last_awaddr <= awaddr;
    end
    if (wvalid) begin
      n_w <= n_w + 1;
      last_wdata <= wdata;
    end
    if (bready) n_b <= n_b + 1;
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic we, input logic uns,
                      input logic [31:0] addr, input logic [1:0] sz,
                      input logic [31:0] wd);
    @(negedge clk);
    req_valid    = 1'b1;
    req_we       = we;
    req_unsigned = uns;
    req_addr     = addr;
    req_size     = sz;
    req_wdata    = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int bound, input int aw_rel,
                          output int lat, output logic err,
                          output logic [31:0] data);
    lat  = -1;
    err  = 1'b0;
    data = '0;
    for (int k = 1; k <= bound; k++) begin
      @(negedge clk);
      if (k == aw_rel) awready = 1'b1;
      if (rsp_valid) begin
        lat  = k;
        err  = rsp_err;
        data = rsp_rdata;
        break;
      end
    end
    if (lat < 0) begin
      chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    end else begin
      @(negedge clk);
      chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  int          lat;
  logic        err;
  logic [31:0] data;
  int          s_ar, s_aw, s_w, s_b, s_rsp;

  task automatic snap();
    s_ar  = n_ar;
    s_aw  = n_aw;
    s_w   = n_w;
    s_b   = n_b;
    s_rsp = n_rsp;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busout",
        {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // load word, readies high
    rdata = 32'hDEAD_BEEF;
    snap();
    send(1'b0, 1'b0, 32'h0000_0010, 2'd2, 32'h0);
    wait_rsp(20, 0, lat, err, data);
    chk("lw_lat", lat, 32'd4);
    chk("lw_data", data, 32'hDEAD_BEEF);
    chk("lw_err", {31'd0, err}, 32'd0);
    chk("lw_araddr", last_araddr, 32'h0000_0010);
    chk("lw_npulse", n_rsp - s_rsp, 32'd1);

    // signed / unsigned byte
    rdata = 32'h0000_0080;
    send(1'b0, 1'b0, 32'h0000_0021, 2'd0, 32'h0);
    wait_rsp(20, 0, lat, err, data);
    chk("lb_data", data, 32'hFFFF_FF80);
    send(1'b0, 1'b1, 32'h0000_0021, 2'd0, 32'h0);
    wait_rsp(20, 0, lat, err, data);
    chk("lbu_data", data, 32'h0000_0080);

    // signed / unsigned half
    rdata = 32'h1234_8001;
    send(1'b0, 1'b0, 32'h0000_0042, 2'd1, 32'h0);
    wait_rsp(20, 0, lat, err, data);
    chk("lh_data", data, 32'hFFFF_8001);
    send(1'b0, 1'b1, 32'h0000_0042, 2'd1, 32'h0);
    wait_rsp(20, 0, lat, err, data);
    chk("lhu_data", data, 32'h0000_8001);

    // store word, readies high
    snap();
    send(1'b1, 1'b0, 32'h0000_0100, 2'd2, 32'hCAFE_F00D);
    wait_rsp(20, 0, lat, err, data);
    chk("sw_lat", lat, 32'd4);
    chk("sw_data", data, 32'h0);
    chk("sw_err", {31'd0, err}, 32'd0);
    chk("sw_awaddr", last_awaddr, 32'h0000_0100);
    chk("sw_wdata", last_wdata, 32'hCAFE_F00D);
    chk("sw_nar", n_ar - s_ar, 32'd0);

    // store with awready delayed 3 cycles
    awready = 1'b0;
    snap();
    send(1'b1, 1'b0, 32'h0000_0200, 2'd2, 32'h1111_2222);
    wait_rsp(30, 3, lat, err, data);
    chk("swd_lat", lat, 32'd6);
    chk("swd_naw", n_aw - s_aw, 32'd3);
    chk("swd_nw", n_w - s_w, 32'd1);
    chk("swd_nb", n_b - s_b, 32'd1);
    chk("swd_err", {31'd0, err}, 32'd0);

    // misaligned half, misaligned word, reserved size
    snap();
    send(1'b0, 1'b0, 32'h0000_0003, 2'd1, 32'h0);
    wait_rsp(10, 0, lat, err, data);
    chk("mis_h_lat", lat, 32'd1);
    chk("mis_h_err", {31'd0, err}, 32'd1);
    send(1'b1, 1'b0, 32'h0000_0006, 2'd2, 32'h0);
    wait_rsp(10, 0, lat, err, data);
    chk("mis_w_err", {31'd0, err}, 32'd1);
    send(1'b0, 1'b0, 32'h0000_0000, 2'd3, 32'h0);
    wait_rsp(10, 0, lat, err, data);
    chk("mis_sz3_err", {31'd0, err}, 32'd1);
    chk("mis_nbus", (n_ar - s_ar) + (n_aw - s_aw), 32'd0);

    // arready stuck low -> timeout
    arready = 1'b0;
    rdata   = 32'h5555_AAAA;
    snap();
    send(1'b0, 1'b0, 32'h0000_0300, 2'd2, 32'h0);
    wait_rsp(400, 0, lat, err, data);
    chk("to_lat", lat, 32'd257);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_nar", n_ar - s_ar, 32'd256);
    chk("to_arvalid", {31'd0, arvalid}, 32'd0);
    chk("to_idle", {31'd0, req_ready}, 32'd1);
    arready = 1'b1;
    send(1'b0, 1'b0, 32'h0000_0304, 2'd2, 32'h0);
    wait_rsp(20, 0, lat, err, data);
    chk("post_to_lat", lat, 32'd4);
    chk("post_to_data", data, 32'h5555_AAAA);
    chk("post_to_err", {31'd0, err}, 32'd0);

    // reset while waiting in B
    bvalid = 1'b0;
    send(1'b1, 1'b0, 32'h0000_0400, 2'd2, 32'h7);
    repeat (3) @(negedge clk);
    chk("rb_in_b", {31'd0, bready}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    bvalid = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    @(negedge clk);
    chk("rb_busout",
        {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    chk("rb_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (6) @(negedge clk);
    chk("rb_nrsp", n_rsp - s_rsp, 32'd0);
    chk("rb_nb", n_b - s_b, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles spent waiting on any one bus handshake.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have core request ports:
- req_valid, input, 1
- req_ready, output, 1
- req_we, input, 1 (1 = store)
- req_unsigned, input, 1 (1 = zero-extend a load)
- req_addr, input, 32
- req_size, input, 2 (0 = byte, 1 = half, 2 = word)
- req_wdata, input, 32 (LSB-aligned)
REQ-005 SHALL have core response ports:
- rsp_valid, output, 1
- rsp_rdata, output, 32 (extended load data)
- rsp_err, output, 1
REQ-006 SHALL have bus ports:
- araddr 32, arsize 2, arvalid 1 (out); arready 1 (in)
- rdata 32, rvalid 1 (in); rready 1 (out)
- awaddr 32, awsize 2, awvalid 1 (out); awready 1 (in)
- wdata 32, wvalid 1 (out); wready 1 (in)
- bvalid 1 (in); bready 1 (out)

Function
REQ-007 SHALL implement exactly these states: IDLE, AR, R, AWW, B, RESP.
REQ-008 SHALL assert req_ready only in IDLE; a request is accepted on req_valid & req_ready, and SHALL register req_addr, req_size, req_wdata, req_we and req_unsigned on acceptance.
REQ-009 SHALL flag an accepted request as misaligned when:
- req_size = 3, or
- req_size = 1 and req_addr[0] = 1, or
- req_size = 2 and req_addr[1:0] != 0.
A misaligned request SHALL go IDLE -> RESP with rsp_err = 1 and SHALL produce no bus activity.
REQ-010 An aligned load SHALL go IDLE -> AR.
- arvalid = 1 with araddr/arsize stable until the cycle arready = 1 is sampled.
- Then -> R with rready = 1 until rvalid = 1 is sampled.
- On that cycle capture rdata, then -> RESP.
REQ-011 An aligned store SHALL go IDLE -> AWW.
- awvalid and wvalid assert together.
- Each deasserts independently in the cycle after its own ready is sampled.
- Leave AWW once both handshakes have completed (same cycle or different cycles).
- Then -> B with bready = 1 until bvalid = 1 is sampled, then -> RESP.
REQ-012 SHALL keep all bus valids registered, with no combinational path from any ready input to any valid output.
REQ-013 In RESP, SHALL assert rsp_valid for exactly one cycle, then return to IDLE; the core has no backpressure on the response.
REQ-014 SHALL form rsp_rdata from rdata[7:0] or rdata[15:0] for size 0 or 1, sign-extended unless req_unsigned = 1; size 2 passes rdata unchanged; stores return rsp_rdata = 0.
REQ-015 SHALL run a cycle counter that clears on every state change.
- In AR, R, AWW or B, a count reaching TIMEOUT SHALL force all bus valids/readies to 0 and go -> RESP with rsp_err = 1.
REQ-016 SHALL keep rsp_err = 0 for completed transactions; the bus carries no error response.
REQ-017 Minimum latency, with bus readies held high, from the acceptance cycle to the rsp_valid cycle: load 4 cycles, store 4 cycles, misaligned 1 cycle.

Reset
REQ-018 On rst_n low, SHALL immediately go to IDLE.
REQ-019 On rst_n low, SHALL drive to 0: arvalid, rready, awvalid, wvalid, bready, rsp_valid, rsp_err, rsp_rdata, the captured registers and the counter.
REQ-020 A reset during any transaction SHALL abandon it silently, with no response pulse after reset release.

Structure
REQ-021 SHALL take the size encodings and state encodings from the shared lsu_defs include.
REQ-022 SHALL place the load extension (REQ-014) in sub-module lsu_load_ext, which is combinational.

Verification
REQ-023 Load word at 0x0000_0010 with readies high and rdata = 0xDEAD_BEEF -> one rsp_valid, rsp_rdata = 0xDEAD_BEEF, rsp_err = 0, at 4 cycles.
REQ-024 Signed byte load with rdata = 0x0000_0080 -> rsp_rdata = 0xFFFF_FF80; same load with req_unsigned = 1 -> rsp_rdata = 0x0000_0080.
REQ-025 Store word with awready delayed 3 cycles and wready immediate -> wvalid drops first, awvalid is held 3 cycles, bready follows, then one rsp_valid.
REQ-026 Half load at 0x0000_0003 -> rsp_err = 1 on the cycle after acceptance, and arvalid/awvalid stay 0 throughout.
REQ-027 Load with arready held 0 for 300 cycles and TIMEOUT = 255 -> arvalid drops, rsp_err = 1, return to IDLE; then a new request completes normally.
REQ-028 rst_n pulsed low during B -> all bus outputs are 0 and req_ready = 1 after release, with no rsp_valid.
